bilinear_interp: RTL and testbench
==================================

# bilinear_interp

Consumes the Q0.8 fractional weights produced by the shift-and-subtract fraction divider, together with the four neighbouring source pixels, and produces one bilinearly interpolated output pixel. It sits directly downstream of the divider in the image-scaling datapath. A single shared two-term lerp datapath is reused over three cycles (top row, bottom row, vertical). Full precision is kept until one final round-half-up.

## Interface
Parameters:
- PIX_W, 8, pixel width (unsigned)
- FRAC_W, 8, fractional weight width (unsigned Q0.FRAC_W; value 1.0 is not representable)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fx/fy/p00..p11 valid
- in_ready  out  1  block can accept; high only in IDLE
- fx  in  FRAC_W  horizontal weight Q0.8 (from divider frac_val)
- fy  in  FRAC_W  vertical weight Q0.8
- p00  in  PIX_W  top-left pixel
- p01  in  PIX_W  top-right pixel
- p10  in  PIX_W  bottom-left pixel
- p11  in  PIX_W  bottom-right pixel
- out_valid  out  1  pix_out valid; held until accepted
- out_ready  in  1  downstream accepts pix_out
- pix_out  out  PIX_W  interpolated pixel

## Operation
- Lerp primitive: L(a,b,f) = a*(2^FRAC_W − f) + b*f. Unsigned, no truncation.
- FSM states: IDLE, H_TOP, H_BOT, VERT, DONE.
- IDLE: in_ready=1. When in_valid=1, latch fx, fy, p00..p11 and go to H_TOP.
- H_TOP: top = L(p00,p01,fx), width PIX_W+FRAC_W (16 b), registered. Go to H_BOT.
- H_BOT: bot = L(p10,p11,fx), registered. Go to VERT.
- VERT: v = L(top,bot,fy), width PIX_W+2·FRAC_W (24 b). Register pix_out = (v + 2^(2·FRAC_W−1)) >> (2·FRAC_W), i.e. round half up. Go to DONE.
- DONE: out_valid=1. pix_out is stable. When out_ready=1, go to IDLE; otherwise hold.
- Result can never exceed 2^PIX_W − 1 (weights < 1.0). No saturation logic is needed.
- fx=0 gives the left pixel exactly. fy=0 gives the top row exactly.
- in_valid is ignored outside IDLE. Latched operands are not affected by input changes after acceptance.
- Reset in any state: go to IDLE on the next edge. The in-flight result is discarded.
- Reset values: in_ready=1 after the reset edge (state IDLE), out_valid=0, pix_out=0, top/bot registers=0.

## Timing
- Accept at edge k (in_valid & in_ready).
- State is H_TOP during the cycle after edge k, H_BOT after edge k+1, VERT after edge k+2, DONE after edge k+3.
- out_valid is visible after edge k+3, so latency is 4 cycles.
- Transfer happens at the first edge with out_valid & out_ready. in_ready is high in the following cycle.
- Peak throughput: 1 pixel per 5 cycles. This is well below the divider's 8-cycle fraction rate, so no stall reaches upstream in steady state.
- in_ready and out_valid are decoded purely from state registers. There are no combinational input-to-output paths.

## Structure
- Shared package bilinear_pkg:
  - state enum {IDLE,H_TOP,H_BOT,VERT,DONE}
  - constants FRAC_ONE = 2^FRAC_W and ROUND_HALF = 2^(2·FRAC_W−1)
  - derived widths H_W = PIX_W+FRAC_W and V_W = PIX_W+2·FRAC_W
- One sub-module, lerp2: combinational, parameterized on operand width A_W and FRAC_W, output A_W+FRAC_W.
  - Instanced once.
  - Operands are muxed by state: (p00,p01,fx), (p10,p11,fx) or (top,bot,fy). 8-bit pixels are zero-extended to H_W.

## Test plan
- fx=0, fy=0, p00=10, others 200 → pix_out=10, out_valid rises 4 cycles after accept.
- fx=0x80, fy=0, p00=p10=0, p01=p11=255 → pix_out=128 (127.5 rounds up).
- fx=fy=0x80, p00=0, p01=100, p10=200, p11=40 → pix_out=85. Checks top=12800, bot=30720.
- fx=fy=0xFF, all pixels 255 → pix_out=255, no overflow.
- Backpressure and handshake:
  - hold out_ready=0 for 6 cycles → out_valid and pix_out stable, in_ready=0, new in_valid ignored
  - release out_ready → transfer, in_ready=1 next cycle
- Assert rst during H_BOT → next cycle IDLE, in_ready=1, out_valid=0, pix_out=0. A subsequent transaction (fx=fy=0, p00=77) → pix_out=77.

Source files
------------

// File: rtl/bilinear_pkg.sv
// Shared definitions for the bilinear interpolator.
//   state_t    : controller states (IDLE, H_TOP, H_BOT, VERT, DONE)
//   FRAC_ONE   : 1.0 in Q0.FRAC_W (one past the largest weight)
//   ROUND_HALF : 0.5 LSB of the final pixel, added before the last shift
//   H_W, V_W   : widths of the row lerp result and the vertical lerp result
// The constants are given for the default 8-bit pixel / 8-bit weight build;
// the top module re-derives its own widths from its parameters.
package bilinear_pkg;

    localparam int DEF_PIX_W  = 8;
    localparam int DEF_FRAC_W = 8;

    localparam int H_W = DEF_PIX_W + DEF_FRAC_W;
    localparam int V_W = DEF_PIX_W + 2 * DEF_FRAC_W;

    localparam int FRAC_ONE   = 1 << DEF_FRAC_W;
    localparam int ROUND_HALF = 1 << (2 * DEF_FRAC_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        H_TOP = 3'd1,
        H_BOT = 3'd2,
        VERT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bilinear_interp_lerp2.sv
// Two-term linear interpolation, purely combinational.
//   a, b : unsigned operands, A_W bits
//   f    : unsigned weight of b in Q0.FRAC_W
//   y    : a*(2^FRAC_W - f) + b*f, full precision (A_W+FRAC_W bits)
// Because f < 1.0 the result never exceeds (2^A_W - 1) * 2^FRAC_W, so
// A_W+FRAC_W bits hold it exactly; the extra bit below only covers the
// intermediate products.
module lerp2 #(
    parameter int A_W    = 16,
    parameter int FRAC_W = 8
) (
    input  logic [A_W-1:0]        a,
    input  logic [A_W-1:0]        b,
    input  logic [FRAC_W-1:0]     f,
    output logic [A_W+FRAC_W-1:0] y
);

    localparam int Y_W = A_W + FRAC_W;

    logic [FRAC_W:0] f_inv;
    logic [Y_W:0]    a_ext;
    logic [Y_W:0]    b_ext;
    logic [Y_W:0]    f_ext;
    logic [Y_W:0]    f_inv_ext;
    logic [Y_W:0]    sum;

    // 2^FRAC_W - f needs one bit more than f (f = 0 gives exactly 1.0).
    assign f_inv     = {1'b1, {FRAC_W{1'b0}}} - {1'b0, f};
    assign a_ext     = {{(FRAC_W + 1){1'b0}}, a};
    assign b_ext     = {{(FRAC_W + 1){1'b0}}, b};
    assign f_ext     = {{(A_W + 1){1'b0}}, f};
    assign f_inv_ext = {{A_W{1'b0}}, f_inv};
    assign sum       = a_ext * f_inv_ext + b_ext * f_ext;
    assign y         = sum[Y_W-1:0];

endmodule

// File: rtl/bilinear_interp.sv
// Bilinear interpolator: one output pixel from four neighbours and Q0.FRAC_W
// weights fx (horizontal) and fy (vertical). A single lerp2 is time-shared:
// top row in H_TOP, bottom row in H_BOT, vertical blend in VERT. Full
// precision is kept until one round-half-up at the end of VERT.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready high only in IDLE)
//   fx, fy              : weights, Q0.FRAC_W
//   p00, p01, p10, p11  : top-left, top-right, bottom-left, bottom-right
//   out_valid/out_ready : output handshake (out_valid high only in DONE)
//   pix_out             : interpolated pixel, stable while out_valid
//   state_dbg           : current controller state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload stable until that edge, and ready/valid
// outputs here are decoded from the state register only.
module bilinear_interp
    import bilinear_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W-1:0] fx,
    input  logic [FRAC_W-1:0] fy,
    input  logic [PIX_W-1:0]  p00,
    input  logic [PIX_W-1:0]  p01,
    input  logic [PIX_W-1:0]  p10,
    input  logic [PIX_W-1:0]  p11,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  pix_out,
    output state_t            state_dbg
);

    localparam int ROW_W = PIX_W + FRAC_W;
    localparam int ACC_W = PIX_W + 2 * FRAC_W;
    localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (2 * FRAC_W - 1);

    state_t            state;
    logic [FRAC_W-1:0] fx_r, fy_r;
    logic [PIX_W-1:0]  p00_r, p01_r, p10_r, p11_r;
    logic [ROW_W-1:0]  top_r, bot_r;

    logic [ROW_W-1:0]  op_a, op_b;
    logic [FRAC_W-1:0] op_f;
    logic [ACC_W-1:0]  lerp_y;

    logic [PIX_W-1:0]      pix_next;
    logic [2*FRAC_W-1:0]   unused_rnd_lo;
    logic                  unused_rnd_hi;

    // Operand mux for the shared lerp; pixels are zero-extended to row width.
    always_comb begin
        op_a = {{FRAC_W{1'b0}}, p00_r};
        op_b = {{FRAC_W{1'b0}}, p01_r};
        op_f = fx_r;
        case (state)
            H_BOT: begin
                op_a = {{FRAC_W{1'b0}}, p10_r};
                op_b = {{FRAC_W{1'b0}}, p11_r};
                op_f = fx_r;
            end
            VERT: begin
                op_a = top_r;
                op_b = bot_r;
                op_f = fy_r;
            end
            default: ;
        endcase
    end

    lerp2 #(
        .A_W   (ROW_W),
        .FRAC_W(FRAC_W)
    ) u_lerp (
        .a(op_a),
        .b(op_b),
        .f(op_f),
        .y(lerp_y)
    );

    // Round half up: add 0.5 LSB of the output, keep the integer part.
    assign {unused_rnd_hi, pix_next, unused_rnd_lo} = {1'b0, lerp_y} + RND;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fx_r    <= '0;
            fy_r    <= '0;
            p00_r   <= '0;
            p01_r   <= '0;
            p10_r   <= '0;
            p11_r   <= '0;
            top_r   <= '0;
            bot_r   <= '0;
            pix_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        fx_r  <= fx;
                        fy_r  <= fy;
                        p00_r <= p00;
                        p01_r <= p01;
                        p10_r <= p10;
                        p11_r <= p11;
                        state <= H_TOP;
                    end
                end
                H_TOP: begin
                    top_r <= lerp_y[ROW_W-1:0];
                    state <= H_BOT;
                end
                H_BOT: begin
                    bot_r <= lerp_y[ROW_W-1:0];
                    state <= VERT;
                end
                VERT: begin
                    pix_out <= pix_next;
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_bilinear_interp.sv
// Self-checking bench for bilinear_interp: directed corner cases, a
// backpressure/ignore-input check, reset in mid-flight, then random traffic
// compared against an arithmetic reference of the bilinear formula.
module tb_bilinear_interp;
    import bilinear_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] fx, fy, p00, p01, p10, p11;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pix_out;
    state_t     state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    bilinear_interp #(.PIX_W(8), .FRAC_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fx       (fx),
        .fy       (fy),
        .p00      (p00),
        .p01      (p01),
        .p10      (p10),
        .p11      (p11),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pix_out  (pix_out),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Weight of the right/bottom sample is f/256; result rounded half up.
    function automatic logic [7:0] ref_pix(input int wx, input int wy,
                                           input int a, input int b,
                                           input int c, input int d);
        longint t, bt, v;
        t  = longint'(a) * (256 - wx) + longint'(b) * wx;
        bt = longint'(c) * (256 - wx) + longint'(d) * wx;
        v  = t * (256 - wy) + bt * wy;
        return 8'((v + 32768) / 65536);
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic randomize_inputs();
        fx  = 8'($urandom_range(0, 255));
        fy  = 8'($urandom_range(0, 255));
        p00 = 8'($urandom_range(0, 255));
        p01 = 8'($urandom_range(0, 255));
        p10 = 8'($urandom_range(0, 255));
        p11 = 8'($urandom_range(0, 255));
    endtask

    // Runs one full transaction; called at a negedge with the DUT idle.
    // During the hold cycles junk is offered on the input to show it is ignored.
    task automatic run_txn(input string tag, input logic [7:0] tfx,
                           input logic [7:0] tfy, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input int hold);
        int w;
        int lat;
        logic [7:0] exp_pix;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        fx = tfx; fy = tfy; p00 = a; p01 = b; p10 = c; p11 = d;
        in_valid = 1'b1;
        exp_q.push_back(ref_pix(tfx, tfy, a, b, c, d));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        randomize_inputs();  // latched operands must not follow the inputs
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        exp_pix = exp_q.pop_front();
        check({tag, "_pix"}, 32'(pix_out), 32'(exp_pix));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            randomize_inputs();
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_pix"}, 32'(pix_out), 32'(exp_pix));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fx = '0; fy = '0; p00 = '0; p01 = '0; p10 = '0; p11 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_pix", 32'(pix_out), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));

        // Directed corner cases.
        run_txn("left_exact", 8'h00, 8'h00, 8'd10, 8'd200, 8'd200, 8'd200, 0);
        run_txn("half_round", 8'h80, 8'h00, 8'd0, 8'd255, 8'd0, 8'd255, 0);
        run_txn("mid_mix", 8'h80, 8'h80, 8'd0, 8'd100, 8'd200, 8'd40, 0);
        check("mid_mix_pix_const", 32'(pix_out), 32'd85);
        check("mid_mix_top", 32'(dut.top_r), 32'd12800);
        check("mid_mix_bot", 32'(dut.bot_r), 32'd30720);
        run_txn("max_weights", 8'hFF, 8'hFF, 8'd255, 8'd255, 8'd255, 8'd255, 0);
        check("max_weights_pix_const", 32'(pix_out), 32'd255);
        run_txn("top_exact", 8'h37, 8'h00, 8'd90, 8'd30, 8'd250, 8'd1, 0);

        // Backpressure: out_ready held low for 6 cycles with junk on input.
        run_txn("backpressure", 8'h40, 8'hC0, 8'd12, 8'd240, 8'd99, 8'd7, 6);

        // Reset while in H_BOT discards the in-flight result.
        fx = 8'h20; fy = 8'h20; p00 = 8'd1; p01 = 8'd2; p10 = 8'd3; p11 = 8'd4;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_state_hbot", 32'(state_dbg), 32'(H_BOT));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", 32'(state_dbg), 32'(IDLE));
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_pix", 32'(pix_out), 32'd0);
        run_txn("after_rst", 8'h00, 8'h00, 8'd77, 8'd5, 8'd6, 8'd8, 0);
        check("after_rst_pix_const", 32'(pix_out), 32'd77);

        // Random traffic with random output backpressure.
        for (int n = 0; n < 40; n++) begin
            run_txn("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
